byte_framer: RTL and testbench

BYTE_FRAMER -- requirements
Module: byte_framer

---
 rtl/byte_framer_if.sv | 21 ++
 rtl/byte_framer.sv | 235 +++++++++++++++++++++++
 tb/tb_byte_framer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_framer_if.sv
// Symbol-in / word-out bundle for byte_framer.
// master = framer side, slave = decoder/consumer side.
interface byte_framer_if;
    logic        sym_valid;
    logic [8:0]  sym_data;
    logic [31:0] word_data;
    logic [3:0]  word_keep;
    logic        word_last;
    logic        word_err;
    logic        word_valid;
    logic        word_ready;

    modport master (
        input  sym_valid, sym_data, word_ready,
        output word_data, word_keep, word_last, word_err, word_valid
    );
    modport slave (
        output sym_valid, sym_data, word_ready,
        input  word_data, word_keep, word_last, word_err, word_valid
    );
endinterface

// File: rtl/byte_framer.sv
// Packs SOF/EOF-delimited decoded bytes into 32-bit words and queues them in a FWFT FIFO.
// Optional macro FRAME_STATS_EN enables the frame_cnt / err_cnt statistics counters.
module byte_framer #(
    parameter int         FIFO_DEPTH = 16,
    parameter int         MAX_WORDS  = 64,
    parameter logic [8:0] SOF_SYM    = 9'h1FB,
    parameter logic [8:0] EOF_SYM    = 9'h1FD
) (
    input  logic                        byteclk,
    input  logic                        rst_n,
    input  logic                        link_up,
    byte_framer_if.master               bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        frame_err,
    output logic [15:0]                 frame_cnt,
    output logic [15:0]                 err_cnt
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int WCW = $clog2(MAX_WORDS + 1);
    localparam logic [LW-1:0]  LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]  LVL_DATA = LW'(FIFO_DEPTH - 1);
    localparam logic [WCW-1:0] WC_MAX   = WCW'(MAX_WORDS);

    typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;

    function automatic logic [3:0] keep_of(input logic [1:0] n);
        case (n)
            2'd1:    keep_of = 4'b0001;
            2'd2:    keep_of = 4'b0011;
            2'd3:    keep_of = 4'b0111;
            default: keep_of = 4'b0000;
        endcase
    endfunction

    // Reset asserts immediately, releases two byteclk edges later
    logic [1:0] rst_sync;
    logic       rst_int_n;
    always_ff @(posedge byteclk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    logic link_p0, link_s;
    always_ff @(posedge byteclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            link_p0 <= 1'b0;
            link_s  <= 1'b0;
        end else begin
            link_p0 <= link_up;
            link_s  <= link_p0;
        end
    end

    state_t         state, state_nx;
    logic [31:0]    stage_word, stage_word_nx, part_word, part_word_nx;
    logic           stage_vld, stage_vld_nx, wr_any, wr_any_nx;
    logic [1:0]     idx, idx_nx;
    logic [WCW-1:0] wcnt, wcnt_nx;
    logic           wr_en, wr_last, wr_err, err_det, term, start;
    logic [31:0]    wr_data;
    logic [3:0]     wr_keep;
    logic           sym_go, pend_any;
    logic [7:0]     sym_byte;

    assign sym_go   = bus.sym_valid && link_s;
    assign sym_byte = bus.sym_data[7:0];
    assign pend_any = stage_vld || (idx != 2'd0);

    always_ff @(posedge byteclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= IDLE;
            stage_word <= '0;
            stage_vld  <= 1'b0;
            part_word  <= '0;
            idx        <= '0;
            wcnt       <= '0;
            wr_any     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            stage_word <= stage_word_nx;
            stage_vld  <= stage_vld_nx;
            part_word  <= part_word_nx;
            idx        <= idx_nx;
            wcnt       <= wcnt_nx;
            wr_any     <= wr_any_nx;
            frame_err  <= err_det;
        end
    end

    always_comb begin
        state_nx      = state;
        stage_word_nx = stage_word;
        stage_vld_nx  = stage_vld;
        part_word_nx  = part_word;
        idx_nx        = idx;
        wcnt_nx       = wcnt;
        wr_any_nx     = wr_any;
        wr_en         = 1'b0;
        wr_data       = '0;
        wr_keep       = '0;
        wr_last       = 1'b0;
        wr_err        = 1'b0;
        err_det       = 1'b0;
        term          = 1'b0;
        start         = 1'b0;
        unique case (state)
            IDLE: begin
                if (sym_go && bus.sym_data == SOF_SYM) start = 1'b1;
            end
            PAYLOAD: begin
                if (!link_s) begin
                    err_det = 1'b1;
                    term    = 1'b1;
                end else if (sym_go) begin
                    if (!bus.sym_data[8]) begin
                        if (stage_vld) begin
                            // Staged word is flushed by the next byte; the last FIFO slot stays free for a terminator
                            if (wcnt == WC_MAX || fifo_level >= LVL_DATA) begin
                                err_det  = 1'b1;
                                term     = 1'b1;
                                state_nx = DROP;
                            end else begin
                                wr_en        = 1'b1;
                                wr_data      = stage_word;
                                wr_keep      = 4'hF;
                                wr_any_nx    = 1'b1;
                                stage_vld_nx = 1'b0;
                                part_word_nx = {24'h0, sym_byte};
                                idx_nx       = 2'd1;
                            end
                        end else if (idx == 2'd3) begin
                            stage_word_nx = {sym_byte, part_word[23:0]};
                            stage_vld_nx  = 1'b1;
                            idx_nx        = 2'd0;
                            wcnt_nx       = wcnt + 1'b1;
                        end else begin
                            part_word_nx[{idx, 3'b000} +: 8] = sym_byte;
                            idx_nx = idx + 2'd1;
                        end
                    end else if (bus.sym_data == EOF_SYM && pend_any) begin
                        wr_en    = 1'b1;
                        wr_data  = stage_vld ? stage_word : part_word;
                        wr_keep  = stage_vld ? 4'hF : keep_of(idx);
                        wr_last  = 1'b1;
                        state_nx = IDLE;
                    end else if (bus.sym_data == SOF_SYM) begin
                        err_det = 1'b1;
                        term    = 1'b1;
                        start   = 1'b1;
                    end else begin
                        err_det  = 1'b1;
                        term     = 1'b1;
                        state_nx = DROP;
                    end
                end
            end
            DROP: begin
                if (sym_go && bus.sym_data == EOF_SYM)      state_nx = IDLE;
                else if (sym_go && bus.sym_data == SOF_SYM) start    = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        if (term && (pend_any || wr_any)) begin
            wr_en   = 1'b1;
            wr_data = !pend_any ? 32'h0 : (stage_vld ? stage_word : part_word);
            wr_keep = !pend_any ? 4'h0 : (stage_vld ? 4'hF : keep_of(idx));
            wr_last = 1'b1;
            wr_err  = 1'b1;
        end
        if (start) begin
            state_nx     = PAYLOAD;
            stage_vld_nx = 1'b0;
            part_word_nx = '0;
            idx_nx       = '0;
            wcnt_nx      = '0;
            wr_any_nx    = 1'b0;
        end
        if (!link_s) state_nx = IDLE;
    end

    // First-word-fall-through FIFO: {err, last, keep, data}
    logic [37:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_wr, do_rd, head_vld;
    logic [37:0]   head;

    assign do_wr    = wr_en && (fifo_level != LVL_FULL);
    assign head_vld = (fifo_level != '0);
    assign do_rd    = bus.word_ready && head_vld;
    assign head     = mem[rp];

    always_ff @(posedge byteclk) begin
        if (do_wr) mem[wp] <= {wr_err, wr_last, wr_keep, wr_data};
    end

    always_ff @(posedge byteclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wp         <= '0;
            rp         <= '0;
            fifo_level <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    assign bus.word_valid = head_vld;
    assign bus.word_data  = head_vld ? head[31:0]  : 32'h0;
    assign bus.word_keep  = head_vld ? head[35:32] : 4'h0;
    assign bus.word_last  = head_vld && head[36];
    assign bus.word_err   = head_vld && head[37];

`ifdef FRAME_STATS_EN
    always_ff @(posedge byteclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (wr_en && wr_last && !wr_err) frame_cnt <= frame_cnt + 1'b1;
            if (err_det)                     err_cnt   <= err_cnt + 1'b1;
        end
    end
`else
    assign frame_cnt = 16'h0;
    assign err_cnt   = 16'h0;
`endif
endmodule

// File: tb/tb_byte_framer.sv
// Directed and randomized bench for byte_framer against a byte-queue reference model.
`timescale 1ns/1ps
module tb_byte_framer;
    localparam int DEPTH = 16;
    localparam int MAXW  = 64;
    localparam logic [8:0] SOF  = 9'h1FB;
    localparam logic [8:0] EOF  = 9'h1FD;
    localparam logic [8:0] K285 = 9'h1BC;
    localparam int ST_IDLE = 0, ST_PAY = 1, ST_DROP = 2;

    logic        byteclk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        link_up = 1'b1;
    logic [4:0]  fifo_level;
    logic        frame_err;
    logic [15:0] frame_cnt, err_cnt;

    byte_framer_if bus();

    byte_framer #(.FIFO_DEPTH(DEPTH), .MAX_WORDS(MAXW)) dut (
        .byteclk    (byteclk),
        .rst_n      (rst_n),
        .link_up    (link_up),
        .bus        (bus),
        .fifo_level (fifo_level),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 byteclk = ~byteclk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        e;
    } ent_t;

    ent_t        mq[$];
    logic [7:0]  pend[$];
    int          m_st, m_nwords;
    bit          m_nwr, m_ferr, m_lp0, m_ls, w_vld;
    ent_t        w_ent;
    logic [15:0] m_fcnt, m_ecnt;
    int          checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t pend_word(input bit last, input bit e);
        ent_t x;
        x = '0;
        for (int i = 0; i < pend.size(); i++) x.d[8*i +: 8] = pend[i];
        x.k = 4'((1 << pend.size()) - 1);
        x.l = last;
        x.e = e;
        return x;
    endfunction

    task automatic m_term();
        if (pend.size() > 0) begin
            w_vld = 1; w_ent = pend_word(1, 1);
        end else if (m_nwr) begin
            w_vld = 1; w_ent = '0; w_ent.l = 1; w_ent.e = 1;
        end
        m_ferr = 1;
    endtask

    task automatic m_start();
        pend.delete(); m_nwords = 0; m_nwr = 0; m_st = ST_PAY;
    endtask

    task automatic model_reset();
        mq.delete(); pend.delete();
        m_st = ST_IDLE; m_nwords = 0; m_nwr = 0; m_ferr = 0;
        m_fcnt = 0; m_ecnt = 0; m_lp0 = link_up; m_ls = link_up;
    endtask

    // One byteclk edge of the framing rules, applied to a queue of pending bytes
    task automatic model_step(input bit v, input logic [8:0] d, input bit rdy);
        int lvl;
        lvl = mq.size(); w_vld = 0; m_ferr = 0;
        if (m_st == ST_PAY && !m_ls) begin
            m_term(); m_st = ST_IDLE;
        end else if (!m_ls) begin
            m_st = ST_IDLE;
        end else if (v) begin
            case (m_st)
                ST_IDLE: if (d == SOF) m_start();
                ST_DROP: begin
                    if (d == EOF) m_st = ST_IDLE;
                    else if (d == SOF) m_start();
                end
                default: begin
                    if (!d[8]) begin
                        if (pend.size() == 4) begin
                            if (m_nwords + 1 > MAXW || lvl >= DEPTH - 1) begin
                                m_term(); m_st = ST_DROP;
                            end else begin
                                w_vld = 1; w_ent = pend_word(0, 0); m_nwr = 1;
                                pend.delete(); pend.push_back(d[7:0]);
                            end
                        end else begin
                            pend.push_back(d[7:0]);
                            if (pend.size() == 4) m_nwords++;
                        end
                    end else if (d == EOF && pend.size() > 0) begin
                        w_vld = 1; w_ent = pend_word(1, 0); m_fcnt++; m_st = ST_IDLE;
                    end else if (d == SOF) begin
                        m_term(); m_start();
                    end else begin
                        m_term(); m_st = ST_DROP;
                    end
                end
            endcase
        end
        if (m_ferr) m_ecnt++;
        if (rdy && lvl > 0) void'(mq.pop_front());
        if (w_vld && lvl < DEPTH) mq.push_back(w_ent);
        m_ls = m_lp0; m_lp0 = link_up;
    endtask

    task automatic check_all();
        ent_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        chk("word_valid", 32'(bus.word_valid), 32'(mq.size() != 0));
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("word_data", bus.word_data, h.d);
        chk("word_keep", 32'(bus.word_keep), 32'(h.k));
        chk("word_last", 32'(bus.word_last), 32'(h.l));
        chk("word_err", 32'(bus.word_err), 32'(h.e));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
`ifdef FRAME_STATS_EN
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
        chk("err_cnt", 32'(err_cnt), 32'(m_ecnt));
`else
        chk("frame_cnt", 32'(frame_cnt), 32'h0);
        chk("err_cnt", 32'(err_cnt), 32'h0);
`endif
    endtask

    task automatic cyc(input bit v, input logic [8:0] d, input bit rdy);
        bus.sym_valid = v; bus.sym_data = d; bus.word_ready = rdy;
        model_step(v, d, rdy);
        @(posedge byteclk); #1;
        check_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 9'h0, rdy);
    endtask

    task automatic do_reset();
        rst_n = 0; link_up = 1;
        bus.sym_valid = 0; bus.sym_data = '0; bus.word_ready = 0;
        #2;
        chk("rst_valid", 32'(bus.word_valid), 32'h0);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_data", bus.word_data, 32'h0);
        chk("rst_keep", 32'(bus.word_keep), 32'h0);
        chk("rst_lasterr", 32'({bus.word_last, bus.word_err}), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_cnts", {frame_cnt, err_cnt}, 32'h0);
        repeat (2) @(posedge byteclk);
        #1 rst_n = 1;
        repeat (5) @(posedge byteclk);
        #1 model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        logic [8:0] s;
        bit rdy;
        do_reset();

        // Two full words
        cyc(1, SOF, 0);
        for (int i = 1; i <= 8; i++) cyc(1, 9'(i), 0);
        cyc(1, EOF, 0);
        chk("r048_level", 32'(fifo_level), 32'd2);
        chk("r048_w0", bus.word_data, 32'h04030201);
        chk("r048_w0last", 32'(bus.word_last), 32'h0);
        cyc(0, 9'h0, 1);
        chk("r048_w1", bus.word_data, 32'h08070605);
        chk("r048_w1kl", 32'({bus.word_keep, bus.word_last}), 32'h1F);
        idle(2, 1);

        // Partial final word
        cyc(1, SOF, 0); cyc(1, 9'h0AA, 0); cyc(1, 9'h0BB, 0); cyc(1, 9'h0CC, 0); cyc(1, EOF, 0);
        chk("r049_data", bus.word_data, 32'h00CCBBAA);
        chk("r049_kle", 32'({bus.word_keep, bus.word_last, bus.word_err}), 32'({4'b0111, 1'b1, 1'b0}));
        idle(2, 1);

        // Unexpected K symbol after one staged word
        cyc(1, SOF, 0);
        for (int i = 0; i < 4; i++) cyc(1, 9'h011 * 9'(i + 1), 0);
        cyc(1, K285, 0);
        chk("r050_ferr", 32'(frame_err), 32'h1);
        cyc(1, 9'h055, 0); cyc(1, 9'h066, 0); cyc(1, EOF, 0);
        chk("r050_level", 32'(fifo_level), 32'd1);
        chk("r050_data", bus.word_data, 32'h44332211);
        chk("r050_kle", 32'({bus.word_keep, bus.word_last, bus.word_err}), 32'({4'hF, 1'b1, 1'b1}));
        idle(2, 1);

        // FIFO overflow with consumer stalled
        cyc(1, SOF, 0);
        for (int i = 1; i <= 80; i++) cyc(1, 9'(i), 0);
        cyc(1, EOF, 0);
        chk("r051_level", 32'(fifo_level), 32'd16);
        idle(15, 1);
        chk("r051_term", bus.word_data, 32'h403F3E3D);
        chk("r051_le", 32'({bus.word_last, bus.word_err}), 32'h3);
        idle(2, 1);

        // Link loss mid-frame
        cyc(1, SOF, 0);
        for (int i = 1; i <= 6; i++) cyc(1, 9'(i), 0);
        link_up = 0;
        idle(4, 0);
        chk("r052_level", 32'(fifo_level), 32'd2);
        chk("r052_w0", bus.word_data, 32'h04030201);
        cyc(0, 9'h0, 1);
        chk("r052_w1", bus.word_data, 32'h00000605);
        chk("r052_kle", 32'({bus.word_keep, bus.word_last, bus.word_err}), 32'({4'b0011, 1'b1, 1'b1}));
        link_up = 1;
        idle(4, 1);

        // SOF-EOF error, then restart inside a frame
        cyc(1, SOF, 1); cyc(1, EOF, 1);
        chk("sofeof_ferr", 32'(frame_err), 32'h1);
        cyc(1, SOF, 0); cyc(1, 9'h001, 0); cyc(1, 9'h002, 0); cyc(1, SOF, 0);
        chk("restart_ferr", 32'(frame_err), 32'h1);
        cyc(1, 9'h003, 0); cyc(1, 9'h004, 0); cyc(1, 9'h005, 0); cyc(1, EOF, 0);
        chk("restart_term", bus.word_data, 32'h00000201);
        idle(1, 1);
        chk("restart_frame", bus.word_data, 32'h00050403);
        idle(2, 1);

        // Word limit exceeded
        cyc(1, SOF, 1);
        for (int i = 0; i < 4 * MAXW + 4; i++) cyc(1, 9'(i & 8'hFF), 1);
        cyc(1, EOF, 1);
        idle(3, 1);

        // Reset with three entries queued
        cyc(1, SOF, 0);
        for (int i = 1; i <= 16; i++) cyc(1, 9'(i), 0);
        chk("r053_pre", 32'(fifo_level), 32'd3);
        do_reset();
        cyc(1, SOF, 0);
        for (int i = 0; i < 5; i++) cyc(1, 9'h0A1 + 9'(i), 0);
        cyc(1, EOF, 0);
        chk("r053_data", bus.word_data, 32'hA4A3A2A1);
        chk("r053_level", 32'(fifo_level), 32'd2);
        idle(3, 1);

        // Randomized symbol stream
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 80)      s = {1'b0, 8'($urandom)};
            else if (r < 87) s = SOF;
            else if (r < 95) s = EOF;
            else if (r < 98) s = K285;
            else             s = {1'b1, 8'($urandom)};
            if (link_up) link_up = ($urandom_range(0, 199) != 0);
            else         link_up = ($urandom_range(0, 3) == 0);
            rdy = (n < 1500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
            cyc($urandom_range(0, 3) != 0, s, rdy);
        end
        link_up = 1;
        idle(30, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
